// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the multiply sequencer, its requester, the pipeline EX stage and the shared ALU.
// Request side: start, mul_a, mul_b in; busy, stall, done, product out.
// Pipeline side: pipe_a, pipe_b, pipe_op, pipe_shift in.
// ALU side: alu_a, alu_b, alu_op, alu_shift out; alu_result in.
interface alu_mul_sequencer_if;
    logic        start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] pipe_a;
    logic [31:0] pipe_b;
    logic [2:0]  pipe_op;
    logic [4:0]  pipe_shift;
    logic [31:0] alu_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [4:0]  alu_shift;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] product;

    // Environment view: requester, pipeline and ALU together
    modport master (
        output start, mul_a, mul_b, pipe_a, pipe_b, pipe_op, pipe_shift, alu_result,
        input  alu_a, alu_b, alu_op, alu_shift, busy, stall, done, product
    );

    // Sequencer view
    modport slave (
        input  start, mul_a, mul_b, pipe_a, pipe_b, pipe_op, pipe_shift, alu_result,
        output alu_a, alu_b, alu_op, alu_shift, busy, stall, done, product
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32-bit multiplier that borrows the shared EX-stage ALU.
// While a multiply runs it owns the ALU (ADD/SLL only) and stalls the pipeline;
// otherwise the pipeline operands pass straight through to the ALU.
// Ports: clk, rst (sync, active high), bus (slave view of alu_mul_sequencer_if).
// Result: product = low 32 bits of mul_a*mul_b, valid from the done pulse.
module alu_mul_sequencer #(
    parameter logic [2:0] OP_ADD     = 3'b010,
    parameter logic [2:0] OP_SLL     = 3'b011,
    parameter bit         EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_mul_sequencer_if.slave   bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned LAST    = 31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SHF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state, datapath updates and ALU mux
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        cnt_d         = cnt_q;
        bus.alu_a     = bus.pipe_a;
        bus.alu_b     = bus.pipe_b;
        bus.alu_op    = bus.pipe_op;
        bus.alu_shift = bus.pipe_shift;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d    = '0;
                    mcand_d  = bus.mul_a;
                    mplier_d = bus.mul_b;
                    cnt_d    = '0;
                    if (EARLY_EXIT && (bus.mul_b == '0)) state_d = S_DONE;
                    else if (bus.mul_b[0])              state_d = S_ADD;
                    else                                state_d = S_SHF;
                end
            end
            S_ADD: begin
                bus.alu_a     = acc_q;
                bus.alu_b     = mcand_q;
                bus.alu_op    = OP_ADD;
                bus.alu_shift = '0;
                acc_d         = bus.alu_result;
                state_d       = S_SHF;
            end
            S_SHF: begin
                bus.alu_a     = mcand_q;
                bus.alu_b     = '0;
                bus.alu_op    = OP_SLL;
                bus.alu_shift = SHIFT_W'(1);
                mcand_d       = bus.alu_result;
                mplier_d      = mplier_q >> 1;
                cnt_d         = cnt_q + CNT_W'(1);
                // Decisions look at the pre-shift multiplier: bit 1 is the next bit to add
                if ((cnt_q == CNT_W'(LAST)) || (EARLY_EXIT && (mplier_q[DATA_W-1:1] == '0)))
                    state_d = S_DONE;
                else if (mplier_q[1])
                    state_d = S_ADD;
                else
                    state_d = S_SHF;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == S_ADD) || (state_q == S_SHF);
    assign bus.stall   = bus.busy;
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = acc_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: one EARLY_EXIT=1 and one EARLY_EXIT=0 instance,
// each driving a small behavioural ALU. Table vectors, hand sequences and random multiplies.
module tb_alu_mul_sequencer;
    logic clk;
    logic rst;

    alu_mul_sequencer_if ifc0 ();
    alu_mul_sequencer_if ifc1 ();

    alu_mul_sequencer #(.OP_ADD(3'b010), .OP_SLL(3'b011), .EARLY_EXIT(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(ifc0)
    );
    alu_mul_sequencer #(.OP_ADD(3'b010), .OP_SLL(3'b011), .EARLY_EXIT(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(ifc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input logic [4:0] sh);
        case (op)
            3'b010:  return a + b;
            3'b011:  return a << sh;
            3'b110:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    logic        start_v [2];
    logic [31:0] ma_v    [2];
    logic [31:0] mb_v    [2];
    logic [31:0] pa, pb;
    logic [2:0]  pop;
    logic [4:0]  psh;

    assign ifc0.start = start_v[0];
    assign ifc0.mul_a = ma_v[0];
    assign ifc0.mul_b = mb_v[0];
    assign ifc1.start = start_v[1];
    assign ifc1.mul_a = ma_v[1];
    assign ifc1.mul_b = mb_v[1];
    assign ifc0.pipe_a = pa;
    assign ifc0.pipe_b = pb;
    assign ifc0.pipe_op = pop;
    assign ifc0.pipe_shift = psh;
    assign ifc1.pipe_a = pa;
    assign ifc1.pipe_b = pb;
    assign ifc1.pipe_op = pop;
    assign ifc1.pipe_shift = psh;
    assign ifc0.alu_result = alu_model(ifc0.alu_a, ifc0.alu_b, ifc0.alu_op, ifc0.alu_shift);
    assign ifc1.alu_result = alu_model(ifc1.alu_a, ifc1.alu_b, ifc1.alu_op, ifc1.alu_shift);

    logic        busy_w  [2];
    logic        stall_w [2];
    logic        done_w  [2];
    logic [31:0] prod_w  [2];
    logic [31:0] alua_w  [2];
    assign busy_w[0] = ifc0.busy;
    assign busy_w[1] = ifc1.busy;
    assign stall_w[0] = ifc0.stall;
    assign stall_w[1] = ifc1.stall;
    assign done_w[0] = ifc0.done;
    assign done_w[1] = ifc1.done;
    assign prod_w[0] = ifc0.product;
    assign prod_w[1] = ifc1.product;
    assign alua_w[0] = ifc0.alu_a;
    assign alua_w[1] = ifc1.alu_a;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference latency from the multiplier's bit pattern
    function automatic int ref_lat(input logic [31:0] b, input bit ee);
        int pc = 0;
        int msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                pc++;
                msb = i;
            end
        end
        if (!ee)     return 33 + pc;
        if (b == 0)  return 1;
        return msb + 1 + pc + 1;
    endfunction

    // Launch one multiply, hold start until done, then watch a few idle cycles.
    task automatic run_mul(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble, output logic [31:0] prod, output int n,
                           output int busy_cyc, output int done_cnt, output int stall_bad,
                           output int pass_bad);
        n = 0; busy_cyc = 0; done_cnt = 0; stall_bad = 0; pass_bad = 0; prod = 'x;
        @(negedge clk);
        start_v[sel] = 1'b1;
        ma_v[sel] = a;
        mb_v[sel] = b;
        @(posedge clk);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (scramble) begin
                ma_v[sel] = $urandom;
                mb_v[sel] = $urandom;
            end
            if (stall_w[sel] !== busy_w[sel]) stall_bad++;
            if (busy_w[sel] === 1'b1) busy_cyc++;
            if (done_w[sel] === 1'b1) begin
                done_cnt++;
                n = k;
                prod = prod_w[sel];
                if (alua_w[sel] !== pa) pass_bad++;
                break;
            end
        end
        start_v[sel] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_w[sel] === 1'b1) done_cnt++;
            if (busy_w[sel] !== 1'b0) busy_cyc++;
            if (prod_w[sel] !== prod) pass_bad++;
            if (alua_w[sel] !== pa) pass_bad++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        int          n;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] prod;
    int          n, bc, dc, sb, pbad, nd;
    logic [31:0] ra, rb;

    initial begin
        tbl[0] = '{a: 32'd7,          b: 32'd6,          p: 32'd42,         n: 6};
        tbl[1] = '{a: 32'hFFFFFFFD,   b: 32'd5,          p: 32'hFFFFFFF1,   n: 6};
        tbl[2] = '{a: 32'hDEADBEEF,   b: 32'd0,          p: 32'd0,          n: 1};
        tbl[3] = '{a: 32'h12345678,   b: 32'hFFFFFFFF,   p: 32'hEDCBA988,   n: 65};
        tbl[4] = '{a: 32'd5,          b: 32'd1,          p: 32'd5,          n: 3};
        tbl[5] = '{a: 32'h00010000,   b: 32'h80000000,   p: 32'd0,          n: 34};
        tbl[6] = '{a: 32'd3,          b: 32'd8,          p: 32'd24,         n: 6};

        start_v[0] = 1'b0; start_v[1] = 1'b0;
        ma_v[0] = '0; ma_v[1] = '0; mb_v[0] = '0; mb_v[1] = '0;
        pa = 32'd9; pb = 32'd4; pop = 3'b110; psh = 5'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle pass-through
        @(negedge clk);
        chk("idle_alu_a", ifc0.alu_a, 32'd9);
        chk("idle_alu_b", ifc0.alu_b, 32'd4);
        chk("idle_alu_op", 32'(ifc0.alu_op), 32'(3'b110));
        chk("idle_alu_shift", 32'(ifc0.alu_shift), 32'd0);
        chk("idle_busy", 32'(ifc0.busy), 32'd0);
        chk("idle_stall", 32'(ifc0.stall), 32'd0);
        chk("idle_done", 32'(ifc0.done), 32'd0);
        chk("idle_product", ifc0.product, 32'd0);
        chk("idle_product1", ifc1.product, 32'd0);

        // ALU ownership during 7*6: first SHF, then ADD of the doubled multiplicand
        start_v[0] = 1'b1; ma_v[0] = 32'd7; mb_v[0] = 32'd6;
        @(posedge clk);
        @(negedge clk);
        chk("shf_alu_a", ifc0.alu_a, 32'd7);
        chk("shf_alu_b", ifc0.alu_b, 32'd0);
        chk("shf_alu_op", 32'(ifc0.alu_op), 32'(3'b011));
        chk("shf_alu_shift", 32'(ifc0.alu_shift), 32'd1);
        chk("shf_stall", 32'(ifc0.stall), 32'd1);
        @(negedge clk);
        chk("add_alu_a", ifc0.alu_a, 32'd0);
        chk("add_alu_b", ifc0.alu_b, 32'd14);
        chk("add_alu_op", 32'(ifc0.alu_op), 32'(3'b010));
        chk("add_alu_shift", 32'(ifc0.alu_shift), 32'd0);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifc0.done === 1'b1) begin
                nd = k + 3;
                break;
            end
        end
        start_v[0] = 1'b0;
        chk("seq_done_cycle", 32'(nd), 32'd6);
        chk("seq_product", ifc0.product, 32'd42);
        chk("seq_done_passthru", ifc0.alu_a, 32'd9);
        repeat (2) @(negedge clk);

        // Table vectors on the early-exit instance
        for (int i = 0; i < 7; i++) begin
            run_mul(0, tbl[i].a, tbl[i].b, 1'b0, prod, n, bc, dc, sb, pbad);
            chk($sformatf("tbl%0d_product", i), prod, tbl[i].p);
            chk($sformatf("tbl%0d_latency", i), 32'(n), 32'(tbl[i].n));
            chk($sformatf("tbl%0d_busy_cycles", i), 32'(bc), 32'(tbl[i].n - 1));
            chk($sformatf("tbl%0d_done_pulses", i), 32'(dc), 32'd1);
            chk($sformatf("tbl%0d_stall", i), 32'(sb), 32'd0);
            chk($sformatf("tbl%0d_passthru", i), 32'(pbad), 32'd0);
        end

        // Reset in cycle 10 of the worst case aborts with no done
        @(negedge clk);
        start_v[0] = 1'b1; ma_v[0] = 32'h12345678; mb_v[0] = 32'hFFFFFFFF;
        @(posedge clk);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 32'(ifc0.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        start_v[0] = 1'b0;
        pa = 32'h0BADF00D;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(ifc0.busy), 32'd0);
        chk("rst_stall", 32'(ifc0.stall), 32'd0);
        chk("rst_done", 32'(ifc0.done), 32'd0);
        chk("rst_product", ifc0.product, 32'd0);
        chk("rst_passthru", ifc0.alu_a, 32'h0BADF00D);
        nd = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (ifc0.done === 1'b1) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'd0);

        // No early exit: operands scrambled after acceptance
        run_mul(1, 32'd3, 32'd2, 1'b1, prod, n, bc, dc, sb, pbad);
        chk("ee0_product", prod, 32'd6);
        chk("ee0_latency", 32'(n), 32'd34);
        chk("ee0_busy_cycles", 32'(bc), 32'd33);
        chk("ee0_done_pulses", 32'(dc), 32'd1);

        // Random multiplies against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            int sel;
            sel = (i % 6 == 5) ? 1 : 0;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 10 == 3) rb = '0;
            pa = $urandom; pb = $urandom; pop = 3'($urandom); psh = 5'($urandom);
            run_mul(sel, ra, rb, (i % 2 == 1), prod, n, bc, dc, sb, pbad);
            chk($sformatf("rnd%0d_product", i), prod, ra * rb);
            chk($sformatf("rnd%0d_latency", i), 32'(n), 32'(ref_lat(rb, (sel == 0))));
            chk($sformatf("rnd%0d_busy_cycles", i), 32'(bc), 32'(ref_lat(rb, (sel == 0)) - 1));
            chk($sformatf("rnd%0d_done_pulses", i), 32'(dc), 32'd1);
            chk($sformatf("rnd%0d_aux", i), 32'(sb + pbad), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
